// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined LEGv8 immediate generator with 2-entry skid and error counting
module imm_extend_pipe #(
    parameter int OUT_W     = 64,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 resetl,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [25:0]          Imm26,
    input  logic [2:0]           Ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     BusImm,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam logic [7:0] OUT_W_B = 8'(OUT_W);

    logic [1:0]           state_q,    state_d;
    logic [OUT_W-1:0]     main_q,     main_d;
    logic                 main_err_q, main_err_d;
    logic [OUT_W-1:0]     skid_q,     skid_d;
    logic                 skid_err_q, skid_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic                 in_ready_q, in_ready_d;

    logic [63:0]          ext_full;
    logic [OUT_W-1:0]     ext_imm;
    logic                 ext_illegal;
    logic [7:0]           movz_top;
    logic                 accept;
    logic                 out_fire;

    assign accept    = in_valid & in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_fire  = out_valid & out_ready;

    // Extend/shift the incoming field to 64 bits; the low OUT_W bits are kept.
    // MOVZ is illegal when its 16-bit chunk would land above OUT_W.
    always_comb begin
        ext_full    = '0;
        ext_illegal = 1'b0;
        movz_top    = {2'b00, Imm26[22:21], 4'b0000} + 8'd16;
        case (Ctrl)
            3'b000: ext_full = {{55{Imm26[20]}}, Imm26[20:12]};
            3'b001: ext_full = {{52{Imm26[21]}}, Imm26[21:10]};
            3'b010: ext_full = {{45{Imm26[23]}}, Imm26[23:5]};
            3'b011: ext_full = {{38{Imm26[25]}}, Imm26[25:0]};
            3'b100: begin
                if (movz_top > OUT_W_B) begin
                    ext_illegal = 1'b1;
                end else begin
                    ext_full = {48'd0, Imm26[20:5]} << {Imm26[22:21], 4'b0000};
                end
            end
            3'b101: ext_full = {52'd0, Imm26[21:10]};
            3'b110: ext_full = {{43{Imm26[23]}}, Imm26[23:5], 2'b00};
            default: ext_full = {{36{Imm26[25]}}, Imm26[25:0], 2'b00};
        endcase
        ext_imm = ext_full[OUT_W-1:0];
    end

    // Next-state for the main/skid pair; main always drives the outputs.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        main_err_d = main_err_q;
        skid_d     = skid_q;
        skid_err_d = skid_err_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d     = ext_imm;
                    main_err_d = ext_illegal;
                    state_d    = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && out_fire) begin
                    main_d     = ext_imm;
                    main_err_d = ext_illegal;
                end else if (accept) begin
                    skid_d     = ext_imm;
                    skid_err_d = ext_illegal;
                    state_d    = S_TWO;
                end else if (out_fire) begin
                    state_d    = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    main_d     = skid_q;
                    main_err_d = skid_err_q;
                    state_d    = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (accept && ext_illegal && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        in_ready_d = (state_d != S_TWO);
    end

    // State and data registers; reset discards everything held and blocks input for one cycle.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            main_err_q <= 1'b0;
            skid_q     <= '0;
            skid_err_q <= 1'b0;
            err_cnt_q  <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            main_err_q <= main_err_d;
            skid_q     <= skid_d;
            skid_err_q <= skid_err_d;
            err_cnt_q  <= err_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign BusImm   = main_q;
    assign out_err  = main_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe at OUT_W 32/48/64
module tb_imm_extend_pipe;

    logic        CLK = 1'b0;
    logic        resetl = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [25:0] Imm26 = '0;
    logic [2:0]  Ctrl = '0;

    logic        ir32, ir48, ir64;
    logic        ov32, ov48, ov64;
    logic        oe32, oe48, oe64;
    logic [31:0] b32;
    logic [47:0] b48;
    logic [63:0] b64;
    logic [1:0]  ec32;
    logic [7:0]  ec48, ec64;

    always #5 CLK = ~CLK;

    imm_extend_pipe #(.OUT_W(32), .ERR_CNT_W(2)) dut32 (
        .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(ir32), .Imm26(Imm26), .Ctrl(Ctrl),
        .out_valid(ov32), .out_ready(out_ready), .BusImm(b32), .out_err(oe32), .err_cnt(ec32));
    imm_extend_pipe #(.OUT_W(48), .ERR_CNT_W(8)) dut48 (
        .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(ir48), .Imm26(Imm26), .Ctrl(Ctrl),
        .out_valid(ov48), .out_ready(out_ready), .BusImm(b48), .out_err(oe48), .err_cnt(ec48));
    imm_extend_pipe #(.OUT_W(64), .ERR_CNT_W(8)) dut64 (
        .CLK(CLK), .resetl(resetl), .in_valid(in_valid), .in_ready(ir64), .Imm26(Imm26), .Ctrl(Ctrl),
        .out_valid(ov64), .out_ready(out_ready), .BusImm(b64), .out_err(oe64), .err_cnt(ec64));

    int n_vec = 0;
    int n_fail = 0;
    int n_deliv = 0;
    int cyc = 0;

    logic [28:0] sq[$];
    int          ecnt[3];
    logic        rst_last = 1'b1;
    int          widths[3] = '{32, 48, 64};
    int          emax[3]   = '{3, 255, 255};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sx(input int f, input int bits);
        return (f >= (1 << (bits - 1))) ? f - (1 << bits) : f;
    endfunction

    // Reference: value of the immediate as an integer, then reduced modulo 2^outw.
    function automatic void model(input logic [25:0] imm, input logic [2:0] ctrl, input int outw,
                                  output logic [63:0] val, output logic err);
        longint v;
        int     hw;
        v   = 0;
        err = 1'b0;
        case (ctrl)
            3'd0: v = longint'(sx(int'(imm[20:12]), 9));
            3'd1: v = longint'(sx(int'(imm[21:10]), 12));
            3'd2: v = longint'(sx(int'(imm[23:5]), 19));
            3'd3: v = longint'(sx(int'(imm), 26));
            3'd4: begin
                hw = int'(imm[22:21]);
                if (16 * hw + 16 > outw) err = 1'b1;
                else v = longint'(imm[20:5]) * (longint'(1) << (16 * hw));
            end
            3'd5: v = longint'(imm[21:10]);
            3'd6: v = longint'(sx(int'(imm[23:5]), 19)) * 4;
            default: v = longint'(sx(int'(imm), 26)) * 4;
        endcase
        val = (outw == 64) ? 64'(v) : (64'(v) & ((64'd1 << outw) - 64'd1));
    endfunction

    // Model update on each edge: pop on delivery, push on acceptance, count illegal ops.
    always @(posedge CLK) begin
        logic        rdy;
        logic        fire;
        logic [63:0] v;
        logic        e;
        cyc++;
        if (!resetl) begin
            sq.delete();
            for (int k = 0; k < 3; k++) ecnt[k] = 0;
            rst_last = 1'b1;
        end else begin
            rdy  = !rst_last && (sq.size() < 2);
            fire = (sq.size() > 0) && out_ready;
            if (fire) void'(sq.pop_front());
            if (in_valid && rdy) begin
                sq.push_back({Ctrl, Imm26});
                for (int k = 0; k < 3; k++) begin
                    model(Imm26, Ctrl, widths[k], v, e);
                    if (e && ecnt[k] < emax[k]) ecnt[k]++;
                end
            end
            rst_last = 1'b0;
        end
    end

    task automatic chk_dut(input int k, input logic ov, input logic ir, input logic [63:0] bus,
                           input logic oe, input int ec);
        logic [63:0] v;
        logic        e;
        chk($sformatf("out_valid_w%0d", widths[k]), 64'(ov), 64'(sq.size() > 0));
        chk($sformatf("in_ready_w%0d", widths[k]), 64'(ir), 64'(!rst_last && sq.size() < 2));
        chk($sformatf("err_cnt_w%0d", widths[k]), 64'(ec), 64'(ecnt[k]));
        if (sq.size() > 0) begin
            model(sq[0][25:0], sq[0][28:26], widths[k], v, e);
            chk($sformatf("BusImm_w%0d", widths[k]), bus, v);
            chk($sformatf("out_err_w%0d", widths[k]), 64'(oe), 64'(e));
        end
    endtask

    // Compare process, away from the active edge.
    always @(negedge CLK) begin
        chk_dut(0, ov32, ir32, 64'(b32), oe32, int'(ec32));
        chk_dut(1, ov48, ir48, 64'(b48), oe48, int'(ec48));
        chk_dut(2, ov64, ir64, b64, oe64, int'(ec64));
        if (ov64 && out_ready) n_deliv++;
    end

    task automatic send(input logic [25:0] imm, input logic [2:0] ctrl);
        logic r;
        Imm26    = imm;
        Ctrl     = ctrl;
        in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge CLK);
            r = ir64;
            @(posedge CLK);
            #1;
            if (r) break;
            if (t > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic lit_op(input string nm, input logic [25:0] imm, input logic [2:0] ctrl,
                          input logic [63:0] e64, input logic [31:0] e32, input logic err32);
        send(imm, ctrl);
        in_valid = 1'b0;
        @(negedge CLK);
        chk({nm, "_lit64"}, b64, e64);
        chk({nm, "_lit32"}, 64'(b32), 64'(e32));
        chk({nm, "_literr32"}, 64'(oe32), 64'(err32));
        chk({nm, "_litvalid"}, 64'(ov64), 64'd1);
        idle(1);
    endtask

    initial begin
        int c0;
        int d0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_bus64", b64, 64'd0);
        chk("reset_valid", 64'(ov64), 64'd0);
        chk("reset_ready", 64'(ir64), 64'd0);
        @(posedge CLK);
        #1;
        resetl    = 1'b1;
        out_ready = 1'b1;
        idle(2);

        lit_op("D_2000000",  26'h2000000, 3'd0, 64'h0, 32'h0, 1'b0);
        lit_op("D_1FFFFFF",  26'h1FFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        lit_op("I_2000000",  26'h2000000, 3'd1, 64'h0, 32'h0, 1'b0);
        lit_op("I_1FFFFFF",  26'h1FFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        lit_op("CB_2000000", 26'h2000000, 3'd2, 64'h0, 32'h0, 1'b0);
        lit_op("CB_1FFFFFF", 26'h1FFFFFF, 3'd2, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        lit_op("B_2000000",  26'h2000000, 3'd3, 64'hFFFFFFFFFE000000, 32'hFE000000, 1'b0);
        lit_op("B_1FFFFFF",  26'h1FFFFFF, 3'd3, 64'h0000000001FFFFFF, 32'h01FFFFFF, 1'b0);
        lit_op("MOVZ_hw3",   26'h077DDE0, 3'd4, 64'hBEEF000000000000, 32'h0, 1'b1);
        chk("errcnt32_one", 64'(ec32), 64'd1);
        lit_op("MOVZ_hw1",   26'h037DDE0, 3'd4, 64'h00000000BEEF0000, 32'hBEEF0000, 1'b0);
        lit_op("IZ_FFF",     26'h03FFC00, 3'd5, 64'h0000000000000FFF, 32'h00000FFF, 1'b0);
        lit_op("CB2_one",    26'h0000020, 3'd6, 64'h4, 32'h4, 1'b0);
        lit_op("B2_3FFFFFF", 26'h3FFFFFF, 3'd7, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0);
        lit_op("MOVZ_hw2",   26'h057DDE0, 3'd4, 64'h0000BEEF00000000, 32'h0, 1'b1);

        for (int i = 0; i < 3; i++) send(26'h057DDE0, 3'd4);
        idle(3);
        chk("errcnt32_sat", 64'(ec32), 64'd3);
        chk("errcnt48", 64'(ec48), 64'd1);
        chk("errcnt64", 64'(ec64), 64'd0);

        d0 = n_deliv;
        fork
            begin
                for (int i = 0; i < 10; i++) send(26'(i * 26'h0123457), 3'(i));
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge CLK);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_delivered", 64'(n_deliv - d0), 64'd10);

        c0 = cyc;
        for (int i = 0; i < 6; i++) send(26'(i * 26'h0377111), 3'(7 - i));
        chk("throughput_cycles", 64'(cyc - c0), 64'd6);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            Imm26     = 26'($urandom);
            Ctrl      = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLK);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        out_ready = 1'b0;
        send(26'h077DDE0, 3'd4);
        send(26'h1234567, 3'd3);
        in_valid = 1'b0;
        resetl   = 1'b0;
        @(posedge CLK);
        #1;
        resetl    = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        chk("rstmid_valid", 64'(ov64), 64'd0);
        chk("rstmid_bus64", b64, 64'd0);
        chk("rstmid_bus32", 64'(b32), 64'd0);
        chk("rstmid_err32", 64'(oe32), 64'd0);
        chk("rstmid_errcnt32", 64'(ec32), 64'd0);
        chk("rstmid_ready", 64'(ir64), 64'd0);
        @(negedge CLK);
        chk("rstrel_ready", 64'(ir64), 64'd1);
        @(posedge CLK);
        #1;
        lit_op("post_rst_B", 26'h2000000, 3'd3, 64'hFFFFFFFFFE000000, 32'hFE000000, 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
